sll_seq_shifter: RTL and testbench

//  Multi-cycle logical shift-left unit. Performs one 1-bit left shift per clock

---
 rtl/sll_seq_shifter_pkg.sv | 19 +
 rtl/sll_seq_shifter_n1.sv | 20 ++
 rtl/sll_seq_shifter.sv | 137 +++++++++++++
 tb/tb_sll_seq_shifter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/sll_seq_shifter_pkg.sv
// Shared definitions for the sequential shift-left unit: FSM state encodings,
// default geometry and the rotate fill helper.
package sll_seq_shifter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int N_DEF  = 8;
  localparam int SW_DEF = 3;

  // Bit shifted into bit 0: the departing MSB when rotating, otherwise zero.
  function automatic logic fill_bit(input logic rot, input logic msb);
    return rot & msb;
  endfunction

endpackage

// File: rtl/sll_seq_shifter_n1.sv
// sll_n1: combinational single-position left shifter with a bypass enable.
module sll_n1 #(
  parameter int N = 8
) (
  input  logic [N-1:0] A,
  input  logic         fill,
  input  logic         en,
  output logic [N-1:0] C
);

  // Shift by one when enabled, otherwise pass the operand through.
  always_comb begin
    if (en) begin
      C = {A[N-2:0], fill};
    end else begin
      C = A;
    end
  end

endmodule

// File: rtl/sll_seq_shifter.sv
// sll_seq_shifter: multi-cycle logical shift-left, one bit per clock, with a
// start/done handshake. Define SHL_ROTATE_EN to add the rot port (rotate left).
module sll_seq_shifter
  import sll_seq_shifter_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int SW = SW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  A,
  input  logic [SW-1:0] shamt,
`ifdef SHL_ROTATE_EN
  input  logic          rot,
`endif
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  C,
  output logic          carry_out
);

  state_e        state_r;
  state_e        state_nx_s;
  logic [N-1:0]  work_r;
  logic [SW-1:0] count_r;
  logic [N-1:0]  shift_s;
  logic          fill_s;
  logic          accept_s;
  logic          zero_amt_s;
  logic          last_s;

  assign accept_s   = start & ((state_r == ST_IDLE) | (state_r == ST_DONE));
  assign zero_amt_s = (shamt == {SW{1'b0}});
  // Final shift edge: the one that leaves the count at zero.
  assign last_s     = (state_r == ST_SHIFT) & (count_r <= SW'(1));

`ifdef SHL_ROTATE_EN
  logic rot_r;

  // Latch the rotate mode alongside the operand on an accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      rot_r <= 1'b0;
    end else if (accept_s) begin
      rot_r <= rot;
    end
  end

  assign fill_s = fill_bit(rot_r, work_r[N-1]);
`else
  assign fill_s = 1'b0;
`endif

  sll_n1 #(.N(N)) u_shift (
    .A    (work_r),
    .fill (fill_s),
    .en   (state_r == ST_SHIFT),
    .C    (shift_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic; start is only honoured from IDLE or DONE.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (accept_s) begin
          state_nx_s = zero_amt_s ? ST_DONE : ST_SHIFT;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (last_s) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_SHIFT;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Status outputs decoded from the state register.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_r)
      ST_SHIFT: busy = 1'b1;
      ST_DONE:  done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Working register and shift counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      work_r  <= {N{1'b0}};
      count_r <= {SW{1'b0}};
    end else if (accept_s) begin
      work_r  <= A;
      count_r <= shamt;
    end else if (state_r == ST_SHIFT) begin
      work_r <= shift_s;
      if (count_r != {SW{1'b0}}) begin
        count_r <= count_r - SW'(1);
      end
    end
  end

  // Result register: written only on the edge entering DONE, held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      C         <= {N{1'b0}};
      carry_out <= 1'b0;
    end else if (accept_s && zero_amt_s) begin
      C         <= A;
      carry_out <= 1'b0;
    end else if (last_s) begin
      C         <= shift_s;
      carry_out <= work_r[N-1];
    end
  end

endmodule

// File: tb/tb_sll_seq_shifter.sv
// Directed self-checking bench for sll_seq_shifter (default N=8, SW=3).
module tb_sll_seq_shifter;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] A;
  logic [2:0] shamt;
`ifdef SHL_ROTATE_EN
  logic       rot;
`endif
  logic       busy;
  logic       done;
  logic [7:0] C;
  logic       carry_out;

  int vectors = 0;
  int miscompares = 0;

  sll_seq_shifter dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .A         (A),
    .shamt     (shamt),
`ifdef SHL_ROTATE_EN
    .rot       (rot),
`endif
    .busy      (busy),
    .done      (done),
    .C         (C),
    .carry_out (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Step until done is seen (bounded); returns edges taken and busy cycles seen.
  task automatic wait_done(output int cyc, output int bcnt);
    cyc  = 0;
    bcnt = 0;
    while (!done && cyc < 20) begin
      if (busy) bcnt++;
      step();
      cyc++;
    end
  endtask

  // Accept one operation, then wait for done; ends in the DONE cycle.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [2:0] sh,
                        input logic [7:0] exp_c, input logic exp_co);
    int cyc;
    int bcnt;
    start = 1'b1;
    A     = a;
    shamt = sh;
    step();
    start = 1'b0;
    A     = 8'h00;
    shamt = 3'd0;
    wait_done(cyc, bcnt);
    chk({tag, "_latency"}, 32'(cyc + 1), 32'(sh) + 32'd1);
    chk({tag, "_busy_cycles"}, 32'(bcnt), 32'(sh));
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_C"}, 32'(C), 32'(exp_c));
    chk({tag, "_carry"}, 32'(carry_out), 32'(exp_co));
  endtask

  initial begin
    int cyc;
    int bcnt;
    int seen_done;

    rst   = 1'b1;
    start = 1'b0;
    A     = 8'h00;
    shamt = 3'd0;
`ifdef SHL_ROTATE_EN
    rot   = 1'b0;
`endif
    step();
    step();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_C", 32'(C), 32'd0);
    chk("reset_carry", 32'(carry_out), 32'd0);
    rst = 1'b0;
    step();

    // 1: B5 << 3 = A8, last bit out = 1
    run_op("t1", 8'hB5, 3'd3, 8'hA8, 1'b1);
    step();
    chk("t1_done_pulse", 32'(done), 32'd0);
    chk("t1_C_hold", 32'(C), 32'h0000_00A8);

    // 2: zero shift amount completes in one cycle
    run_op("t2", 8'h5A, 3'd0, 8'h5A, 1'b0);
    step();

    // 3: FF << 7, then a back-to-back request issued in the DONE cycle
    run_op("t3a", 8'hFF, 3'd7, 8'h80, 1'b1);
    run_op("t3b", 8'h01, 3'd2, 8'h04, 1'b0);
    step();

    // 4: start during SHIFT must be ignored
    start = 1'b1;
    A     = 8'h0F;
    shamt = 3'd5;
    step();
    start = 1'b0;
    chk("t4_busy_e0", 32'(busy), 32'd1);
    chk("t4_C_hold_e0", 32'(C), 32'h0000_0004);
    step();
    start = 1'b1;
    A     = 8'hFF;
    shamt = 3'd1;
    step();
    start = 1'b0;
    wait_done(cyc, bcnt);
    chk("t4_remaining_edges", 32'(cyc), 32'd3);
    chk("t4_C", 32'(C), 32'h0000_00E0);
    chk("t4_carry", 32'(carry_out), 32'd1);
    step();

    // 5: reset at edge 3 discards the operation
    start = 1'b1;
    A     = 8'h3C;
    shamt = 3'd6;
    step();
    start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_C", 32'(C), 32'd0);
    chk("t5_carry", 32'(carry_out), 32'd0);
    seen_done = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done || busy) seen_done++;
    end
    chk("t5_no_done", 32'(seen_done), 32'd0);

`ifdef SHL_ROTATE_EN
    // 6: rotate vs logical shift on the same operand
    rot = 1'b1;
    run_op("t6_rot", 8'h81, 3'd1, 8'h03, 1'b1);
    rot = 1'b0;
    step();
    run_op("t6_sll", 8'h81, 3'd1, 8'h02, 1'b1);
    step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
